// File: rtl/action_encoder_pkg.sv
// Shared definitions for the per-player action code bus: action codes,
// button indices and the fixed-priority press encoder.
package action_encoder_pkg;

    localparam logic [2:0] ACT_IDLE   = 3'b000;
    localparam logic [2:0] ACT_LEFT   = 3'b001;
    localparam logic [2:0] ACT_RIGHT  = 3'b010;
    localparam logic [2:0] ACT_ATTACK = 3'b011;
    localparam logic [2:0] ACT_DEFEND = 3'b100;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_ATTACK = 2;
    localparam int BTN_DEFEND = 3;
    localparam int NUM_BTNS   = 4;

    // Simultaneous presses resolve to one winner: DEFEND > ATTACK > LEFT > RIGHT.
    function automatic logic [2:0] pick_action(input logic [NUM_BTNS-1:0] press);
        logic [2:0] code;
        code = ACT_IDLE;
        if (press[BTN_DEFEND])      code = ACT_DEFEND;
        else if (press[BTN_ATTACK]) code = ACT_ATTACK;
        else if (press[BTN_LEFT])   code = ACT_LEFT;
        else if (press[BTN_RIGHT])  code = ACT_RIGHT;
        return code;
    endfunction

endpackage

// File: rtl/action_encoder_button_debouncer.sv
// One push-button: 2-flop synchroniser, stability counter, debounced level
// and a single-cycle rise pulse on each debounced 0->1 transition.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic rise
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any cycle where the sample agrees with the level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = level_q & ~prev_q;

endmodule

// File: rtl/action_encoder.sv
// Per-player action encoder: debounced button presses become a one-entry
// pending action that is presented on the action bus at each game tick.
module action_encoder
    import action_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       tick,
    output logic [2:0] action,
    output logic       pending_valid,
    input  logic       overrun_clr,
    output logic       overrun
);

    logic [NUM_BTNS-1:0] rise;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debouncer (
                .clk     (clk),
                .reset   (reset),
                .btn_raw (btn[gi]),
                .rise    (rise[gi])
            );
        end
    endgenerate

    logic [2:0] action_q, action_d;
    logic [2:0] pend_code_q, pend_code_d;
    logic       pending_valid_q, pending_valid_d;
    logic       overrun_q, overrun_d;
    logic       press_any;
    logic [2:0] winner;
    logic       overrun_set;

    always_comb begin
        press_any       = |rise;
        winner          = pick_action(rise);
        action_d        = action_q;
        pend_code_d     = pend_code_q;
        pending_valid_d = pending_valid_q;
        overrun_set     = 1'b0;
        if (tick) begin
            // The tick consumes the old entry, so a same-cycle press is never an overrun.
            action_d        = pending_valid_q ? pend_code_q : ACT_IDLE;
            pending_valid_d = press_any;
            pend_code_d     = press_any ? winner : ACT_IDLE;
        end else if (press_any) begin
            pend_code_d     = winner;
            pending_valid_d = 1'b1;
            overrun_set     = pending_valid_q;
        end
        overrun_d = overrun_set | (overrun_q & ~overrun_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            action_q        <= ACT_IDLE;
            pend_code_q     <= ACT_IDLE;
            pending_valid_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            action_q        <= action_d;
            pend_code_q     <= pend_code_d;
            pending_valid_q <= pending_valid_d;
            overrun_q       <= overrun_d;
        end
    end

    assign action        = action_q;
    assign pending_valid = pending_valid_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_action_encoder.sv
// Self-checking bench for action_encoder with DEBOUNCE_CYCLES=4: a behavioural
// model checked every cycle, plus directed literal expectations.
module tb_action_encoder;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn = 4'b0;
    logic       tick = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [2:0] action;
    logic       pending_valid;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    action_encoder #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn           (btn),
        .tick          (tick),
        .action        (action),
        .pending_valid (pending_valid),
        .overrun_clr   (overrun_clr),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Model: a button's debounced level flips once the raw level, seen two
    // edges late, has disagreed with it for DC edges running.
    logic [3:0] raw_hist[$];
    int         run[4];
    logic [3:0] m_lvl, m_lvl_prev;
    logic [2:0] m_action, m_pend;
    logic       m_pv, m_ovr;

    function automatic logic [2:0] model_winner(input logic [3:0] p);
        if (p[3]) return 3'd4;
        if (p[2]) return 3'd3;
        if (p[0]) return 3'd1;
        if (p[1]) return 3'd2;
        return 3'd0;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [3:0] s;
        logic [3:0] press;
        if (reset) begin
            raw_hist = '{4'b0, 4'b0};
            for (int b = 0; b < 4; b++) run[b] = 0;
            m_lvl = 4'b0; m_lvl_prev = 4'b0;
            m_action = 3'd0; m_pend = 3'd0; m_pv = 1'b0; m_ovr = 1'b0;
        end else begin
            s = raw_hist.pop_front();
            raw_hist.push_back(btn);
            press = m_lvl & ~m_lvl_prev;
            if (tick) begin
                m_action = m_pv ? m_pend : 3'd0;
                m_pv = (press != 4'b0);
                m_pend = model_winner(press);
                m_ovr = m_ovr & ~overrun_clr;
            end else begin
                m_ovr = (press != 4'b0 && m_pv) | (m_ovr & ~overrun_clr);
                if (press != 4'b0) begin
                    m_pend = model_winner(press);
                    m_pv = 1'b1;
                end
            end
            m_lvl_prev = m_lvl;
            for (int b = 0; b < 4; b++) begin
                if (s[b] != m_lvl[b]) begin
                    run[b]++;
                    if (run[b] == DC) begin
                        m_lvl[b] = ~m_lvl[b];
                        run[b] = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (action !== m_action) begin
            errors++;
            $display("FAIL cyc_action t=%0t dut=%0d model=%0d", $time, action, m_action);
        end
        checks++;
        if (pending_valid !== m_pv) begin
            errors++;
            $display("FAIL cyc_pending t=%0t dut=%0d model=%0d", $time, pending_valid, m_pv);
        end
        checks++;
        if (overrun !== m_ovr) begin
            errors++;
            $display("FAIL cyc_overrun t=%0t dut=%0d model=%0d", $time, overrun, m_ovr);
        end
    end

    task automatic lit(input string name, input int dut_val, input int model_val, input int exp_val);
        checks++;
        if (dut_val != exp_val) begin
            errors++;
            $display("FAIL %s dut=%0d required=%0d", name, dut_val, exp_val);
        end
        checks++;
        if (model_val != exp_val) begin
            errors++;
            $display("FAIL %s_model model=%0d required=%0d", name, model_val, exp_val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        step(2);
        lit("rst_action", action, m_action, 0);
        lit("rst_pending", pending_valid, m_pv, 0);
        lit("rst_overrun", overrun, m_ovr, 0);

        // ATTACK held from cycle 0: pending at edge 7, consumed, then idle.
        reset = 1'b0;
        btn[2] = 1'b1;
        step(6);
        lit("t1_pv_edge6", pending_valid, m_pv, 0);
        step(1);
        lit("t1_pv_edge7", pending_valid, m_pv, 1);
        pulse_tick();
        lit("t1_action", action, m_action, 3);
        lit("t1_pv_after", pending_valid, m_pv, 0);
        btn[2] = 1'b0;
        step(10);
        pulse_tick();
        lit("t1_idle", action, m_action, 0);
        $display("txn1 attack press/consume/idle done");

        // Short LEFT glitch is filtered out.
        btn[0] = 1'b1;
        step(3);
        btn[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(3);
            pulse_tick();
            lit("t2_action", action, m_action, 0);
            lit("t2_pv", pending_valid, m_pv, 0);
        end
        $display("txn2 glitch rejected");

        // DEFEND and RIGHT in the same cycle; then back-to-back ticks.
        btn[3] = 1'b1;
        btn[1] = 1'b1;
        step(10);
        lit("t3_pv", pending_valid, m_pv, 1);
        tick = 1'b1;
        step(1);
        lit("t3_action", action, m_action, 4);
        lit("t3_overrun", overrun, m_ovr, 0);
        step(1);
        tick = 1'b0;
        lit("t3_b2b_idle", action, m_action, 0);
        btn[3] = 1'b0;
        btn[1] = 1'b0;
        step(10);
        $display("txn3 simultaneous press priority done");

        // LEFT then RIGHT before a tick: overrun, RIGHT wins, then clear.
        btn[0] = 1'b1;
        step(10);
        btn[0] = 1'b0;
        step(10);
        btn[1] = 1'b1;
        step(10);
        lit("t4_overrun", overrun, m_ovr, 1);
        pulse_tick();
        lit("t4_action", action, m_action, 2);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        lit("t4_ovr_clr", overrun, m_ovr, 0);
        btn[1] = 1'b0;
        step(10);
        pulse_tick();
        $display("txn4 overrun and clear done");

        // LEFT press lands on the tick that consumes a pending ATTACK.
        btn[2] = 1'b1;
        step(10);
        btn[0] = 1'b1;
        step(6);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        lit("t5_action", action, m_action, 3);
        lit("t5_pv", pending_valid, m_pv, 1);
        lit("t5_overrun", overrun, m_ovr, 0);
        btn = 4'b0;
        step(10);
        pulse_tick();
        lit("t5_action2", action, m_action, 1);
        lit("t5_overrun2", overrun, m_ovr, 0);
        $display("txn5 press on tick done");

        // Reset mid-pending with action=DEFEND clears without a clock edge.
        btn[3] = 1'b1;
        step(10);
        pulse_tick();
        btn[3] = 1'b0;
        step(10);
        btn[3] = 1'b1;
        step(10);
        lit("t6_pre_action", action, m_action, 4);
        lit("t6_pre_pv", pending_valid, m_pv, 1);
        #2;
        reset = 1'b1;
        #1;
        lit("t6_action", action, m_action, 0);
        lit("t6_pv", pending_valid, m_pv, 0);
        lit("t6_overrun", overrun, m_ovr, 0);
        btn = 4'b0;
        step(3);
        reset = 1'b0;
        step(10);
        lit("t6_post_pv", pending_valid, m_pv, 0);
        $display("txn6 async reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
